sample_buffer: RTL and testbench
================================

Name: sample_buffer

Overview:
- Capture memory directly downstream of the trigger/sequencing state machine.
- Writes one DATA_W-bit probe sample per clock while the capture-enable (ce) strobe is high, into a circular buffer of 2^ADDR_W entries.
- When the capture-done flag rises, presents the captured samples to the host read port oldest-first, one word per request, via a request/valid handshake.
- Clears and re-arms itself when the done flag drops.

Parameters:
- DATA_W, 8: sample width in bits.
- ADDR_W, 10: address width; depth DEPTH = 2^ADDR_W = 1024 entries.

Ports:
- in_clk  input  1  sole clock; all logic on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_sample  input  DATA_W  probe sample bus, sampled on the rising edge of in_clk.
- in_ce  input  1  capture enable from the state machine; write in_sample this cycle.
- in_done  input  1  capture-complete level from the state machine (its done/P3 flag).
- in_rd_req  input  1  host read request, one word per cycle high.
- out_data  output  DATA_W  read data; meaningful only while out_valid is high.
- out_valid  output  1  one-cycle strobe; out_data holds a captured sample.
- out_last  output  1  high with out_valid on the final (newest) sample.
- out_full  output  1  buffer holds DEPTH samples; the oldest has been overwritten at least once.
- out_count  output  ADDR_W+1  number of valid samples stored, 0..DEPTH.

Behaviour:
- Reset (in_rst_n low, asynchronous):
  - state=CAPTURE; wr_ptr=0, rd_ptr=0, count=0, remaining=0, done_q=0.
  - out_data=0, out_valid=0, out_last=0, out_full=0, out_count=0.
  - Memory contents are not reset.
- done_q is a registered copy of in_done. A rise is in_done & ~done_q; a fall is ~in_done & done_q.
- States: CAPTURE, READOUT, DRAINED.
- CAPTURE:
  - When in_ce=1: mem[wr_ptr] <= in_sample; wr_ptr increments modulo DEPTH (1023 wraps to 0); count increments and saturates at DEPTH.
  - out_full = (count == DEPTH); out_count = count.
  - On a rise of in_done, go to READOUT:
    - rd_ptr <= (count == DEPTH) ? wr_ptr : 0, using the post-write wr_ptr if in_ce is also high that cycle.
    - remaining <= post-write count.
    - If the post-write count is 0, go to DRAINED instead.
  - in_ce and the in_done rise in the same cycle: the sample is written and included in readout.
  - in_rd_req is ignored; out_valid stays 0.
- READOUT:
  - in_ce is ignored; no writes occur.
  - If in_rd_req=1 and remaining>0: read mem[rd_ptr]; the next cycle drives out_data=sample and out_valid=1. Read latency is exactly 1 cycle.
  - rd_ptr increments modulo DEPTH; remaining decrements.
  - in_rd_req may stay high every cycle, giving back-to-back words at full rate.
  - The word issued with remaining==1 has out_last=1. On its issue cycle the state goes to DRAINED; its out_valid still appears on the next cycle.
  - out_valid and out_last are 0 in every cycle that follows no accepted request.
- DRAINED:
  - No reads or writes; in_rd_req is ignored.
  - out_valid=0 except for the pending final word.
  - count, out_full and out_count keep their capture values for host inspection.
- Fall of in_done in READOUT or DRAINED (state machine went idle or re-armed):
  - Next state is CAPTURE; wr_ptr=0, count=0, remaining=0.
  - out_full and out_count go to 0 in the same cycle.
  - Any word already issued still produces its out_valid. No new requests are accepted.
  - Abort mid-READOUT is legal; unread samples are discarded.
- A fall of in_done in CAPTURE has no effect.
- count width is ADDR_W+1 so that DEPTH is representable. out_count is the registered count.

Test Plan:
- Reset: assert in_rst_n=0 mid-capture -> all outputs 0 immediately (asynchronous); after release, out_count=0 and state CAPTURE.
- Partial fill: in_ce high for 5 cycles with samples 0x10..0x14, raise in_done, hold in_rd_req high 5 cycles -> out_valid on 5 consecutive cycles with 0x10,0x11,0x12,0x13,0x14; out_last only on 0x14; out_full=0; out_count=5.
- Wrap: in_ce high 1030 cycles with sample=cycle index mod 256, then in_done -> out_full=1, out_count=1024; first word read = index 6 (0x06), last word = index 1029 (0x05) with out_last.
- Simultaneous: in_ce=1 with sample 0xAA in the same cycle in_done rises (after 2 prior samples) -> 3 words read, the last being 0xAA.
- Sparse requests: in_rd_req pulsed every 3rd cycle -> out_valid exactly 1 cycle after each pulse; requests after out_last produce nothing.
- Abort: drop in_done after 2 of 10 words are read -> the already-issued word appears, no further out_valid; out_count=0; a new 3-sample capture then reads back only those 3 samples.

Source files
------------

// File: rtl/sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sample_buffer                                                   |
// | Brief    : circular capture memory, replayed oldest-first after done rises |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sample_buffer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              in_ce,
   input  logic              in_done,
   input  logic              in_rd_req,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              out_full,
   output logic [ADDR_W:0]   out_count
);

   localparam int              c_DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(c_DEPTH);
   localparam logic [ADDR_W:0] c_ONE_CNT   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_ONE_PTR = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_READOUT = 2'd1,
      ST_DRAINED = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt, w_wr_ptr_post;
   logic [ADDR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
   logic [ADDR_W:0]     r_count, w_count_nxt, w_count_post;
   logic [ADDR_W:0]     r_remaining, w_remaining_nxt;
   logic                r_done_q;
   logic [DATA_W-1:0]   r_data;
   logic                r_valid, r_last;
   logic                w_wr_en, w_rd_en, w_rise, w_fall;
   logic [DATA_W-1:0]   r_mem [c_DEPTH];

   assign w_rise = in_done & ~r_done_q;
   assign w_fall = ~in_done & r_done_q;

   // Pointer and count as they stand after this cycle's write, so a sample
   // written in the same cycle done rises is part of the readout.
   assign w_wr_ptr_post = in_ce ? (r_wr_ptr + c_ONE_PTR) : r_wr_ptr;
   assign w_count_post  = (in_ce && (r_count != c_DEPTH_CNT)) ? (r_count + c_ONE_CNT) : r_count;

   always_comb begin
      w_state_nxt     = r_state;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_count_nxt     = r_count;
      w_remaining_nxt = r_remaining;
      w_wr_en         = 1'b0;
      w_rd_en         = 1'b0;
      case (r_state)
         ST_CAPTURE: begin
            w_wr_en      = in_ce;
            w_wr_ptr_nxt = w_wr_ptr_post;
            w_count_nxt  = w_count_post;
            if (w_rise) begin
               w_remaining_nxt = w_count_post;
               w_rd_ptr_nxt    = (w_count_post == c_DEPTH_CNT) ? w_wr_ptr_post : '0;
               w_state_nxt     = (w_count_post == '0) ? ST_DRAINED : ST_READOUT;
            end
         end
         ST_READOUT: begin
            if (w_fall) begin
               w_state_nxt     = ST_CAPTURE;
               w_wr_ptr_nxt    = '0;
               w_count_nxt     = '0;
               w_remaining_nxt = '0;
            end else if (in_rd_req && (r_remaining != '0)) begin
               w_rd_en         = 1'b1;
               w_rd_ptr_nxt    = r_rd_ptr + c_ONE_PTR;
               w_remaining_nxt = r_remaining - c_ONE_CNT;
               if (r_remaining == c_ONE_CNT)
                  w_state_nxt = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (w_fall) begin
               w_state_nxt     = ST_CAPTURE;
               w_wr_ptr_nxt    = '0;
               w_count_nxt     = '0;
               w_remaining_nxt = '0;
            end
         end
         default: w_state_nxt = ST_CAPTURE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr] <= in_sample;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state     <= ST_CAPTURE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_remaining <= '0;
         r_done_q    <= 1'b0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_count     <= w_count_nxt;
         r_remaining <= w_remaining_nxt;
         r_done_q    <= in_done;
         r_valid     <= w_rd_en;
         r_last      <= w_rd_en && (r_remaining == c_ONE_CNT);
         if (w_rd_en)
            r_data <= r_mem[r_rd_ptr];
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign out_count = r_count;
   assign out_full  = (r_count == c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sample_buffer                                                |
// | Brief    : directed self-checking bench for sample_buffer                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sample_buffer;

   logic        in_clk;
   logic        in_rst_n;
   logic [7:0]  in_sample;
   logic        in_ce;
   logic        in_done;
   logic        in_rd_req;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_full;
   logic [10:0] out_count;

   int total = 0;
   int bad   = 0;

   sample_buffer #(.DATA_W(8), .ADDR_W(10)) dut (
      .in_clk    (in_clk),
      .in_rst_n  (in_rst_n),
      .in_sample (in_sample),
      .in_ce     (in_ce),
      .in_done   (in_done),
      .in_rd_req (in_rd_req),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_full  (out_full),
      .out_count (out_count)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // stimulus only: n samples base, base+1, ... starting at a falling edge
   task automatic capture_seq(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         in_ce     = 1'b1;
         in_sample = 8'(base + i);
         @(negedge in_clk);
      end
      in_ce = 1'b0;
   endtask

   task automatic test_reset();
      in_rst_n = 1'b0; in_ce = 1'b0; in_done = 1'b0; in_rd_req = 1'b0; in_sample = '0;
      repeat (2) @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_count !== 11'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", out_count); end
      total++; if (out_full !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00)
         begin bad++; $display("FAIL reset_outs got full=%b last=%b data=%h exp 0/0/00", out_full, out_last, out_data); end
      in_rst_n = 1'b1;
      @(negedge in_clk);
      capture_seq(3, 8'h55);
      total++; if (out_count !== 11'd3) begin bad++; $display("FAIL pre_reset_count got=%0d exp=3", out_count); end
      #2 in_rst_n = 1'b0;
      #1;
      total++; if (out_count !== 11'd0) begin bad++; $display("FAIL async_reset_count got=%0d exp=0", out_count); end
      @(negedge in_clk);
      in_rst_n = 1'b1;
      @(negedge in_clk);
      total++; if (out_count !== 11'd0 || out_valid !== 1'b0)
         begin bad++; $display("FAIL post_reset got count=%0d valid=%b exp 0/0", out_count, out_valid); end
   endtask

   task automatic test_partial();
      capture_seq(5, 8'h10);
      in_done = 1'b1;
      @(negedge in_clk);
      total++; if (out_count !== 11'd5) begin bad++; $display("FAIL partial_count got=%0d exp=5", out_count); end
      total++; if (out_full !== 1'b0) begin bad++; $display("FAIL partial_full got=%b exp=0", out_full); end
      in_rd_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge in_clk);
         total++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i) || out_last !== (i == 4))
            begin bad++; $display("FAIL partial_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                  i, out_valid, out_data, out_last, 8'(8'h10 + i), (i == 4)); end
      end
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL partial_after_last got=%b exp=0", out_valid); end
      total++; if (out_count !== 11'd5) begin bad++; $display("FAIL drained_count got=%0d exp=5", out_count); end
      in_rd_req = 1'b0;
      in_done   = 1'b0;
      @(negedge in_clk);
      total++; if (out_count !== 11'd0) begin bad++; $display("FAIL rearm_count got=%0d exp=0", out_count); end
   endtask

   task automatic test_wrap();
      capture_seq(1030, 8'h00);
      in_done = 1'b1;
      @(negedge in_clk);
      total++; if (out_full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", out_full); end
      total++; if (out_count !== 11'd1024) begin bad++; $display("FAIL wrap_count got=%0d exp=1024", out_count); end
      in_rd_req = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         @(negedge in_clk);
         total++; if (out_valid !== 1'b1 || out_data !== 8'((k + 6) % 256) || out_last !== (k == 1023))
            begin bad++; $display("FAIL wrap_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                  k, out_valid, out_data, out_last, 8'((k + 6) % 256), (k == 1023)); end
      end
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_after_last got=%b exp=0", out_valid); end
      in_rd_req = 1'b0;
      in_done   = 1'b0;
      @(negedge in_clk);
      total++; if (out_full !== 1'b0) begin bad++; $display("FAIL wrap_rearm_full got=%b exp=0", out_full); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'hAA;
      capture_seq(2, 8'h01);
      in_ce = 1'b1; in_sample = 8'hAA; in_done = 1'b1;
      @(negedge in_clk);
      in_ce = 1'b0;
      total++; if (out_count !== 11'd3) begin bad++; $display("FAIL simul_count got=%0d exp=3", out_count); end
      in_rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge in_clk);
         total++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 2))
            begin bad++; $display("FAIL simul_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                  i, out_valid, out_data, out_last, exp_d[i], (i == 2)); end
      end
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL simul_after_last got=%b exp=0", out_valid); end
      in_rd_req = 1'b0;
      in_done   = 1'b0;
      @(negedge in_clk);
   endtask

   task automatic test_sparse();
      capture_seq(4, 8'h20);
      in_done = 1'b1;
      @(negedge in_clk);
      for (int p = 0; p < 6; p++) begin
         in_rd_req = 1'b1;
         @(negedge in_clk);
         in_rd_req = 1'b0;
         total++;
         if (p < 4) begin
            if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + p) || out_last !== (p == 3))
               begin bad++; $display("FAIL sparse_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                     p, out_valid, out_data, out_last, 8'(8'h20 + p), (p == 3)); end
         end else begin
            if (out_valid !== 1'b0) begin bad++; $display("FAIL sparse_extra%0d got v=%b exp=0", p, out_valid); end
         end
         @(negedge in_clk);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sparse_gap%0d got v=%b exp=0", p, out_valid); end
         @(negedge in_clk);
      end
      in_done = 1'b0;
      @(negedge in_clk);
   endtask

   task automatic test_abort();
      capture_seq(10, 8'h30);
      in_done = 1'b1;
      @(negedge in_clk);
      in_rd_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge in_clk);
         total++; if (out_valid !== 1'b1 || out_data !== 8'(8'h30 + i))
            begin bad++; $display("FAIL abort_word%0d got v=%b d=%h exp v=1 d=%h",
                                  i, out_valid, out_data, 8'(8'h30 + i)); end
      end
      in_done = 1'b0;
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_more got=%b exp=0", out_valid); end
      total++; if (out_count !== 11'd0) begin bad++; $display("FAIL abort_count got=%0d exp=0", out_count); end
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", out_valid); end
      in_rd_req = 1'b0;
      capture_seq(3, 8'h40);
      in_done = 1'b1;
      @(negedge in_clk);
      total++; if (out_count !== 11'd3) begin bad++; $display("FAIL recap_count got=%0d exp=3", out_count); end
      in_rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge in_clk);
         total++; if (out_valid !== 1'b1 || out_data !== 8'(8'h40 + i) || out_last !== (i == 2))
            begin bad++; $display("FAIL recap_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                  i, out_valid, out_data, out_last, 8'(8'h40 + i), (i == 2)); end
      end
      @(negedge in_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL recap_after_last got=%b exp=0", out_valid); end
      in_rd_req = 1'b0;
      in_done   = 1'b0;
      @(negedge in_clk);
   endtask

   initial begin
      test_reset();
      test_partial();
      test_wrap();
      test_simultaneous();
      test_sparse();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
